programmer_master: RTL
======================

// Module: programmer_master
// PURPOSE
//  SPI mode-00 master that serialises one NUM_BITS configuration word onto SCLK/SDI/CS.
//  Drives the chip's SPI programmer slave from the test/control FPGA side.
//  The slave shifts SDI into its MSB on SCLK rise, so the word is sent LSB first.
//  The slave latches the word on CS rise, so the frame is applied only when CS returns high.
// PARAMETERS
//  NUM_BITS  59  configuration word length; exactly this many SCLK rising edges per frame
//  CLK_DIV   2   clk cycles per SCLK half-period (>=1); SCLK freq = f_clk/(2*CLK_DIV)
//  CS_SETUP  2   clk cycles from CS fall to first SCLK rise (>=1)
//  CS_HOLD   2   clk cycles from last SCLK fall to CS rise (>=1)
//  CS_IDLE   2   clk cycles CS held high after a frame before busy drops (>=1)
// PORTS
//  clk      in   1         system clock; all logic on posedge
//  reset    in   1         asynchronous, active-low reset
//  start    in   1         frame request; sampled only when busy=0
//  data_in  in   NUM_BITS  word to send; bit 0 goes out first; captured on accepted start
//  busy     out  1         high from the cycle after an accepted start until GAP completes
//  done     out  1         1-cycle pulse, asserted in the cycle CS returns high
//  SCLK     out  1         SPI clock, idles low (CPOL=0)
//  SDI      out  1         SPI data; changes only while SCLK is low
//  CS       out  1         SPI chip select, active low
// BEHAVIOUR
//  - All outputs are registered; no combinational paths from inputs to outputs.
//  - Reset (async, any time, including mid-frame):
//    state=IDLE, CS=1, SCLK=0, SDI=0, busy=0, done=0, shift reg=0, counters=0.
//  - Reset is shared with the slave. A mid-frame master reset raises CS, so the slave must be reset too.
//  - FSM IDLE -> SETUP -> {HIGH <-> LOW} -> HOLD -> GAP -> IDLE.
//  - IDLE: SCLK=0, CS=1, SDI=0. On start=1: load shreg<=data_in, SDI<=data_in[0], CS<=0, busy<=1, enter SETUP.
//  - SETUP: CS_SETUP cycles with SCLK=0, then SCLK<=1 and enter HIGH.
//  - HIGH: SCLK=1 for CLK_DIV cycles; bit_cnt increments on entry.
//  - End of HIGH, bit_cnt<NUM_BITS: SCLK<=0, SDI<=next bit (shreg right-shift), enter LOW.
//  - End of HIGH, bit_cnt==NUM_BITS: SCLK<=0, SDI held, enter HOLD.
//  - LOW: CLK_DIV cycles, then SCLK<=1 and enter HIGH.
//  - HOLD: CS_HOLD cycles, then CS<=1, SDI<=0, done<=1 for one cycle, enter GAP.
//  - GAP: CS_IDLE cycles with CS=1, then busy<=0 and enter IDLE.
//  - CS low duration is exactly CS_SETUP + (2*NUM_BITS-1)*CLK_DIV + CS_HOLD clk cycles.
//    With defaults this is 238 cycles.
//  - Exactly NUM_BITS SCLK rising edges per frame; the k-th rise presents data_in[k-1].
//  - SDI is stable for CLK_DIV cycles before and during each SCLK high phase.
//  - start while busy=1 is ignored, not queued. data_in changes after capture have no effect.
//  - start held high continuously gives back-to-back frames with CS high for exactly CS_IDLE+1 cycles between frames.
//  - bit_cnt width is $clog2(NUM_BITS+1); no wrap within a frame.
// TESTING
//  1. Assert reset, toggle start/data_in -> CS=1, SCLK=0, SDI=0, busy=0, done=0 throughout.
//  2. Defaults, data_in=59'h123_4567_89AB_CDEF, programmer slave attached -> after CS rise:
//     slave GTHDR=8'hEF, GTHSNR=8'hCD, HO=prog_data[58]=0; done pulses once.
//  3. Defaults -> count 59 SCLK rises, CS low 238 cycles, first rise 2 cycles after CS fall,
//     no SDI change while SCLK=1.
//  4. Accepted start, then start=1 with new data_in at cycle 50 -> ignored;
//     shifted word still equals the first data_in; one done pulse.
//  5. start held high, CLK_DIV=1 -> consecutive frames, CS high exactly 3 cycles between them,
//     each frame 2+117+2=121 CS-low cycles.
//  6. reset low after 30th SCLK rise -> CS=1, SCLK=0, busy=0 immediately (async);
//     after release, next start sends a full clean 59-bit frame.

Source files
------------

// File: rtl/programmer_master.sv
// programmer_master: SPI mode-0 master that shifts one NUM_BITS configuration word out LSB first.
// Latency: CS falls one cycle after an accepted start; CS stays low CS_SETUP+(2*NUM_BITS-1)*CLK_DIV+CS_HOLD cycles.
// Backpressure: start is honoured only while busy=0; a start during a frame is dropped, not queued.
// Ports: clk/reset (async, active low), start + data_in (frame request), busy/done (status),
//        SCLK/SDI/CS (SPI pins to the programmer slave). Every output comes straight from a flop.
module programmer_master #(
  parameter int NUM_BITS = 59,
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NUM_BITS-1:0] data_in,
  output logic                busy,
  output logic                done,
  output logic                SCLK,
  output logic                SDI,
  output logic                CS
);

  // One shared phase counter serves every timed state, so size it for the longest phase.
  localparam int MAX_AB  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_CD  = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W   = $clog2(NUM_BITS + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);
  localparam logic [BIT_W-1:0] BITS_ALL   = BIT_W'(NUM_BITS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_t;

  state_t              state;
  logic [NUM_BITS-1:0] shreg;
  logic [CNT_W-1:0]    cnt;
  logic [BIT_W-1:0]    bit_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      CS      <= 1'b1;
      SCLK    <= 1'b0;
      SDI     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      shreg   <= '0;
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= data_in;
            SDI     <= data_in[0];
            CS      <= 1'b0;
            busy    <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= SETUP;
          end
        end

        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt     <= '0;
            SCLK    <= 1'b1;
            bit_cnt <= bit_cnt + BIT_W'(1);
            state   <= HIGH;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        HIGH: begin
          if (cnt == DIV_LAST) begin
            cnt  <= '0;
            SCLK <= 1'b0;
            if (bit_cnt < BITS_ALL) begin
              // shreg[1] is the bit that sits in shreg[0] after this shift. Rotating
              // rather than zero-filling is harmless: the top bits are never sent.
              SDI   <= shreg[1];
              shreg <= {shreg[0], shreg[NUM_BITS-1:1]};
              state <= LOW;
            end else begin
              // Last bit stays on SDI through the hold time.
              state <= HOLD;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        LOW: begin
          if (cnt == DIV_LAST) begin
            cnt     <= '0;
            SCLK    <= 1'b1;
            bit_cnt <= bit_cnt + BIT_W'(1);
            state   <= HIGH;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            CS    <= 1'b1;
            SDI   <= 1'b0;
            done  <= 1'b1;
            state <= GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        GAP: begin
          // CS is then high for CS_IDLE+1 cycles before the next frame can pull it low.
          if (cnt == IDLE_LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
